csr_regfile: RTL and testbench
==============================

Name: csr_regfile

Overview:
- Control/status register file for the LoongArch pipeline; it is the responder to the CSR access, exception and ertn requests that the writeback stage issues.
- Serves combinational CSR reads and masked synchronous CSR writes.
- Records exception context and restores it on ertn.
- Runs the constant timer and aggregates interrupt sources into a single pending-interrupt flag.
- Drives the exception entry and return addresses back to the fetch side.

Parameters:
- EENTRY_RESET, 32'h0, reset value of EENTRY.
- TID_RESET, 32'h0, reset value of TID.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- csr_re  in  1  read enable; csr_rvalue is forced to 0 when low
- csr_num  in  14  CSR address for read/write
- csr_rvalue  out  32  read data (combinational)
- csr_we  in  1  write enable
- csr_wmask  in  32  per-bit write mask
- csr_wvalue  in  32  write data
- wb_ex  in  1  exception commit
- wb_ecode  in  6  exception code
- wb_esubcode  in  9  exception subcode
- wb_pc  in  32  PC of the excepting instruction
- wb_vaddr  in  32  faulting virtual address
- ertn_flush  in  1  ertn commit
- hw_int_in  in  8  hardware interrupt lines (level)
- ipi_int_in  in  1  inter-processor interrupt (level)
- csr_eentry  out  32  exception entry address
- csr_era  out  32  ERA contents
- has_int  out  1  an interrupt is pending and enabled

Behaviour:
- Clock and reset: single clock; reset is synchronous, active-high, on clk/reset.
- Reset values:
  - CRMD = 0x8 (PLV=0, IE=0, DA=1).
  - PRMD, ECFG, ESTAT, ERA, BADV, SAVE0-3, TCFG = 0.
  - EENTRY = EENTRY_RESET; TID = TID_RESET; timer counter = 0xFFFFFFFF.
  - Outputs after reset: csr_eentry = EENTRY_RESET, csr_era = 0, has_int = 0.
- Register map:
  - CRMD 0x0: PLV[1:0], IE[2], DA[3].
  - PRMD 0x1: PPLV[1:0], PIE[2].
  - ECFG 0x4: LIE[12:0], writable mask 0x1BFF.
  - ESTAT 0x5: IS[1:0] software-writable; IS[9:2] hardware; IS[11] timer; IS[12] IPI; Ecode[21:16]; EsubCode[30:22].
  - ERA 0x6; BADV 0x7; EENTRY 0xC (VA[31:6], low 6 bits read 0); SAVE0-3 0x30-0x33; TID 0x40.
  - TCFG 0x41: En[0], Periodic[1], InitVal[31:2].
  - TVAL 0x42: read-only, returns the counter.
  - TICLR 0x44: reads 0; writing bit0 = 1 clears IS[11].
- Reads: combinational, same cycle. Unimplemented addresses and non-field bits read 0.
- Writes: on the clk edge, each field gets new = (old & ~mask) | (wvalue & mask). Read-only fields are unaffected.
- Exception (wb_ex=1):
  - PPLV<=PLV, PIE<=IE; then PLV<=0, IE<=0.
  - Ecode/EsubCode <= inputs; ERA <= wb_pc.
  - BADV <= wb_vaddr only when ecode is 0x08 (ADEF) or 0x09 (ALE).
- ertn (ertn_flush=1): PLV<=PPLV, IE<=PIE. DA is not changed by either event.
- Priority in one cycle: wb_ex > ertn_flush > csr_we. A write issued in the same cycle as wb_ex or ertn_flush is dropped in full.
- Interrupt sampling: IS[9:2] <= hw_int_in and IS[12] <= ipi_int_in every cycle, giving one cycle of latency.
- Timer (evaluated every cycle, first matching rule wins):
  - A TCFG write that leaves En=1 loads the counter with {InitVal,2'b00}.
  - Otherwise, if En=1 and counter != 0xFFFFFFFF:
    - counter == 0: set IS[11]; counter <= Periodic ? {InitVal,2'b00} : 0xFFFFFFFF.
    - otherwise: counter decrements by 1.
  - En=0 freezes the counter.
  - If a timer set and a TICLR clear hit IS[11] in the same cycle, the set wins.
- has_int = |(ESTAT.IS[12:0] & ECFG.LIE[12:0]) & CRMD.IE. It is combinational from register state.

Optional Feature:
- Macro CSR_TIMER_EN.
- Defined: TID, TCFG, TVAL, TICLR and the counter exist as described above.
- Undefined: no counter logic is built; addresses 0x40-0x44 read 0 and writes to them are ignored; IS[11] is constant 0.

Test Plan:
- Reset, then read CRMD (csr_re=1) -> 0x00000008. Reads of ERA, ESTAT and 0x3FFF -> 0. csr_eentry = 0; has_int = 0.
- ERA = 0xAAAAAAAA, then write mask 0x0000FFFF, value 0x12345678 -> ERA reads 0xAAAA5678; csr_era matches the next cycle.
- Write CRMD = 0x7, then wb_ex with ecode 0x0B, pc 0x1C000100, plus a same-cycle csr_we to ERA. Required next-cycle reads:
  - CRMD = 0x8, PRMD = 0x7.
  - ESTAT[21:16] = 0x0B.
  - ERA = 0x1C000100; the ERA write is dropped.
  - BADV unchanged.
- Continuing from the previous scenario, assert ertn_flush -> CRMD = 0xF.
- Timer (CSR_TIMER_EN defined): set ECFG = 0x800 and CRMD.IE = 1, then write TCFG = 0x11.
  - TVAL reads 16 after the write edge.
  - IS[11] and has_int rise 17 edges after the write; TVAL then reads 0xFFFFFFFF.
  - TICLR write 0x1 -> IS[11] = 0 and has_int = 0 the next cycle.
  - Repeat with TCFG = 0x13 (periodic) -> IS[11] re-sets every 17 cycles.
- hw_int_in = 0x01 with LIE = 0 -> ESTAT[2] = 1 one cycle later, has_int = 0. Then set LIE bit2 and IE = 1 -> has_int = 1. Drop hw_int_in -> has_int = 0 one cycle later.

Source files
------------

// File: rtl/csr_regfile.sv
// csr_regfile: LoongArch control/status register file.
// Serves combinational CSR reads and masked synchronous writes from the
// writeback stage. It records exception context, restores it on ertn and
// folds the interrupt sources into has_int.
// The constant timer (TID, TCFG, TVAL, TICLR and the down-counter) is built
// only when the CSR_TIMER_EN macro is defined. Without it, those addresses
// read 0, writes to them are ignored and ESTAT.IS[11] is tied to 0.
`timescale 1ns/1ps
module csr_regfile #(
    parameter logic [31:0] EENTRY_RESET = 32'h0,
    parameter logic [31:0] TID_RESET    = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] csr_eentry,
    output logic [31:0] csr_era,
    output logic        has_int
);

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;

    localparam logic [5:0]  ECODE_ADEF = 6'h08;
    localparam logic [5:0]  ECODE_ALE  = 6'h09;

    // LIE[10] has no interrupt source behind it and stays 0.
    localparam logic [12:0] LIE_MASK   = 13'h1BFF;

    // Architectural state, kept field by field so that non-field bits read as 0.
    logic [1:0]  crmd_plv;
    logic        crmd_ie;
    logic        crmd_da;
    logic [1:0]  prmd_pplv;
    logic        prmd_pie;
    logic [12:0] ecfg_lie;
    logic [1:0]  estat_is_sw;
    logic [7:0]  estat_is_hw;
    logic        estat_is_ti;
    logic        estat_is_ipi;
    logic [5:0]  estat_ecode;
    logic [8:0]  estat_esubcode;
    logic [31:0] era;
    logic [31:0] badv;
    logic [25:0] eentry_va;
    logic [31:0] save [4];

    logic        sw_we;
    logic        save_sel;
    logic [31:0] wr_set;
    logic [31:0] wr_keep;
    logic [12:0] estat_is;
    logic [31:0] rdata;

    // An exception or ertn in the same cycle drops the software write entirely.
    assign sw_we    = csr_we & ~wb_ex & ~ertn_flush;
    assign save_sel = (csr_num[13:2] == CSR_SAVE0[13:2]);

    // Every masked write is new = (old & ~mask) | (wvalue & mask).
    assign wr_set  = csr_wvalue & csr_wmask;
    assign wr_keep = ~csr_wmask;

    // CRMD/PRMD: mode save on exception, restore on ertn, otherwise software writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_plv  <= 2'd0;
            crmd_ie   <= 1'b0;
            crmd_da   <= 1'b1;
            prmd_pplv <= 2'd0;
            prmd_pie  <= 1'b0;
        end else if (wb_ex) begin
            // NOTE: non-blocking assignments let PRMD capture the pre-exception
            // CRMD even though CRMD is cleared on the same edge.
            prmd_pplv <= crmd_plv;
            prmd_pie  <= crmd_ie;
            crmd_plv  <= 2'd0;
            crmd_ie   <= 1'b0;
        end else if (ertn_flush) begin
            crmd_plv  <= prmd_pplv;
            crmd_ie   <= prmd_pie;
        end else if (sw_we) begin
            if (csr_num == CSR_CRMD) begin
                crmd_plv <= (crmd_plv & wr_keep[1:0]) | wr_set[1:0];
                crmd_ie  <= (crmd_ie  & wr_keep[2])   | wr_set[2];
                crmd_da  <= (crmd_da  & wr_keep[3])   | wr_set[3];
            end
            if (csr_num == CSR_PRMD) begin
                prmd_pplv <= (prmd_pplv & wr_keep[1:0]) | wr_set[1:0];
                prmd_pie  <= (prmd_pie  & wr_keep[2])   | wr_set[2];
            end
        end
    end

    // ECFG: local interrupt enables, only the implemented LIE bits are writable.
    always_ff @(posedge clk) begin
        if (reset) begin
            ecfg_lie <= 13'd0;
        end else if (sw_we && csr_num == CSR_ECFG) begin
            ecfg_lie <= (ecfg_lie & (wr_keep[12:0] | ~LIE_MASK)) | (wr_set[12:0] & LIE_MASK);
        end
    end

    // ESTAT: sample interrupt lines every cycle, capture the exception cause, software IS[1:0].
    always_ff @(posedge clk) begin
        if (reset) begin
            estat_is_sw    <= 2'd0;
            estat_is_hw    <= 8'd0;
            estat_is_ipi   <= 1'b0;
            estat_ecode    <= 6'd0;
            estat_esubcode <= 9'd0;
        end else begin
            estat_is_hw  <= hw_int_in;
            estat_is_ipi <= ipi_int_in;
            if (wb_ex) begin
                estat_ecode    <= wb_ecode;
                estat_esubcode <= wb_esubcode;
            end
            if (sw_we && csr_num == CSR_ESTAT) begin
                estat_is_sw <= (estat_is_sw & wr_keep[1:0]) | wr_set[1:0];
            end
        end
    end

    // ERA/BADV: exception return address and faulting address for address exceptions.
    always_ff @(posedge clk) begin
        if (reset) begin
            era  <= 32'd0;
            badv <= 32'd0;
        end else if (wb_ex) begin
            era <= wb_pc;
            if (wb_ecode == ECODE_ADEF || wb_ecode == ECODE_ALE) begin
                badv <= wb_vaddr;
            end
        end else if (sw_we) begin
            if (csr_num == CSR_ERA) begin
                era <= (era & wr_keep) | wr_set;
            end
            if (csr_num == CSR_BADV) begin
                badv <= (badv & wr_keep) | wr_set;
            end
        end
    end

    // EENTRY and SAVE0-3: plain software-owned storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            eentry_va <= EENTRY_RESET[31:6];
            // NOTE: the scratch array is reset to 0, so it is built from
            // resettable flops and not mapped to a RAM macro.
            for (int i = 0; i < 4; i++) begin
                save[i] <= 32'd0;
            end
        end else if (sw_we) begin
            if (csr_num == CSR_EENTRY) begin
                eentry_va <= (eentry_va & wr_keep[31:6]) | wr_set[31:6];
            end
            if (save_sel) begin
                save[csr_num[1:0]] <= (save[csr_num[1:0]] & wr_keep) | wr_set;
            end
        end
    end

`ifdef CSR_TIMER_EN
    localparam logic [13:0] CSR_TID   = 14'h040;
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;
    localparam logic [13:0] CSR_TICLR = 14'h044;

    logic [31:0] tid;
    logic [31:0] tcfg;
    logic [31:0] tval_cnt;
    logic [31:0] tcfg_next;
    logic        tcfg_load;
    logic        timer_fire;
    logic        ticlr_clr;

    assign tcfg_next  = (tcfg & wr_keep) | wr_set;
    assign tcfg_load  = sw_we && (csr_num == CSR_TCFG) && tcfg_next[0];
    // A counter at all-ones is idle, so the zero test alone identifies expiry.
    assign timer_fire = !tcfg_load && tcfg[0] && (tval_cnt == 32'd0);
    assign ticlr_clr  = sw_we && (csr_num == CSR_TICLR) && wr_set[0];

    // Timer: TID/TCFG writes, counter load/decrement/reload, IS[11] set beats clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            tid         <= TID_RESET;
            tcfg        <= 32'd0;
            tval_cnt    <= 32'hFFFF_FFFF;
            estat_is_ti <= 1'b0;
        end else begin
            if (sw_we && csr_num == CSR_TID) begin
                tid <= (tid & wr_keep) | wr_set;
            end
            if (sw_we && csr_num == CSR_TCFG) begin
                tcfg <= tcfg_next;
            end
            if (tcfg_load) begin
                tval_cnt <= {tcfg_next[31:2], 2'b00};
            end else if (tcfg[0] && tval_cnt != 32'hFFFF_FFFF) begin
                if (tval_cnt == 32'd0) begin
                    tval_cnt <= tcfg[1] ? {tcfg[31:2], 2'b00} : 32'hFFFF_FFFF;
                end else begin
                    tval_cnt <= tval_cnt - 32'd1;
                end
            end
            if (timer_fire) begin
                estat_is_ti <= 1'b1;
            end else if (ticlr_clr) begin
                estat_is_ti <= 1'b0;
            end
        end
    end
`else
    assign estat_is_ti = 1'b0;
`endif

    assign estat_is = {estat_is_ipi, estat_is_ti, 1'b0, estat_is_hw, estat_is_sw};

    // Read mux: unimplemented addresses and TICLR fall through to 0.
    always_comb begin
        // NOTE: the default assignment first keeps this mux free of latches.
        rdata = 32'd0;
        case (csr_num)
            CSR_CRMD:   rdata = {28'd0, crmd_da, crmd_ie, crmd_plv};
            CSR_PRMD:   rdata = {29'd0, prmd_pie, prmd_pplv};
            CSR_ECFG:   rdata = {19'd0, ecfg_lie};
            CSR_ESTAT:  rdata = {1'b0, estat_esubcode, estat_ecode, 3'd0, estat_is};
            CSR_ERA:    rdata = era;
            CSR_BADV:   rdata = badv;
            CSR_EENTRY: rdata = {eentry_va, 6'd0};
`ifdef CSR_TIMER_EN
            CSR_TID:    rdata = tid;
            CSR_TCFG:   rdata = tcfg;
            CSR_TVAL:   rdata = tval_cnt;
`endif
            default: begin
                if (save_sel) begin
                    rdata = save[csr_num[1:0]];
                end
            end
        endcase
    end

    assign csr_rvalue = csr_re ? rdata : 32'd0;
    assign csr_eentry = {eentry_va, 6'd0};
    assign csr_era    = era;
    assign has_int    = (|(estat_is & ecfg_lie)) & crmd_ie;

endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed test of csr_regfile against a behavioural model.
// The model keeps every CSR as a whole word in an address-indexed table.
// A single negedge process compares all outputs with the model on every cycle.
// Hand-computed literal reads pin the model along the way.
`timescale 1ns/1ps
module tb_csr_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        has_int;

    int n_checks = 0;
    int n_fail   = 0;
    bit model_valid = 1'b0;

    logic [31:0] mreg [int];

    always #10 clk = ~clk;

    csr_regfile #(
        .EENTRY_RESET(32'h0),
        .TID_RESET   (32'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .csr_re     (csr_re),
        .csr_num    (csr_num),
        .csr_rvalue (csr_rvalue),
        .csr_we     (csr_we),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .wb_ex      (wb_ex),
        .wb_ecode   (wb_ecode),
        .wb_esubcode(wb_esubcode),
        .wb_pc      (wb_pc),
        .wb_vaddr   (wb_vaddr),
        .ertn_flush (ertn_flush),
        .hw_int_in  (hw_int_in),
        .ipi_int_in (ipi_int_in),
        .csr_eentry (csr_eentry),
        .csr_era    (csr_era),
        .has_int    (has_int)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] mget(input int a);
        return mreg.exists(a) ? mreg[a] : 32'h0;
    endfunction

    // Software-writable bits of each implemented CSR; 0 means read-only or absent.
    function automatic logic [31:0] wr_mask(input int a);
        case (a)
            'h00:                   return 32'h0000_000F;
            'h01:                   return 32'h0000_0007;
            'h04:                   return 32'h0000_1BFF;
            'h05:                   return 32'h0000_0003;
            'h06, 'h07:             return 32'hFFFF_FFFF;
            'h0C:                   return 32'hFFFF_FFC0;
            'h30, 'h31, 'h32, 'h33: return 32'hFFFF_FFFF;
`ifdef CSR_TIMER_EN
            'h40, 'h41:             return 32'hFFFF_FFFF;
`endif
            default:                return 32'h0;
        endcase
    endfunction

    function automatic logic exp_has_int();
        logic [31:0] is_bits;
        logic [31:0] lie;
        logic [31:0] crmd;
        is_bits = mget('h05) & 32'h1FFF;
        lie     = mget('h04);
        crmd    = mget('h00);
        return ((is_bits & lie) != 0) && crmd[2];
    endfunction

    task automatic model_reset();
        mreg.delete();
        mreg['h00] = 32'h8;
        foreach (mreg[k]) mreg[k] = mreg[k];
        mreg['h01] = 0; mreg['h04] = 0; mreg['h05] = 0; mreg['h06] = 0; mreg['h07] = 0;
        mreg['h0C] = 32'h0;
        for (int i = 'h30; i <= 'h33; i++) mreg[i] = 0;
`ifdef CSR_TIMER_EN
        mreg['h40] = 32'h0;
        mreg['h41] = 0;
        mreg['h42] = 32'hFFFF_FFFF;
`endif
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int          a;
        logic [31:0] wm;
        logic [31:0] old_tcfg;
        logic [31:0] old_cnt;
        bit          tcfg_load;
        bit          ti_set;
        bit          ti_clr;
        if (reset) begin
            model_reset();
            model_valid = 1'b1;
            return;
        end
        old_tcfg  = mget('h41);
        old_cnt   = mget('h42);
        tcfg_load = 0;
        ti_set    = 0;
        ti_clr    = 0;
        a         = int'(csr_num);
        if (wb_ex) begin
            mreg['h01] = mreg['h00] & 32'h7;
            mreg['h00] = mreg['h00] & 32'h8;
            mreg['h05] = (mreg['h05] & 32'h0000_FFFF) | (32'(wb_esubcode) << 22) | (32'(wb_ecode) << 16);
            mreg['h06] = wb_pc;
            if (wb_ecode == 6'h08 || wb_ecode == 6'h09) mreg['h07] = wb_vaddr;
        end else if (ertn_flush) begin
            mreg['h00] = (mreg['h00] & 32'h8) | (mreg['h01] & 32'h7);
        end else if (csr_we) begin
            wm = csr_wmask & wr_mask(a);
            if (mreg.exists(a)) mreg[a] = (mreg[a] & ~wm) | (csr_wvalue & wm);
`ifdef CSR_TIMER_EN
            if (a == 'h41 && mreg['h41][0]) tcfg_load = 1;
            if (a == 'h44 && csr_wvalue[0] && csr_wmask[0]) ti_clr = 1;
`endif
        end
        mreg['h05] = (mreg['h05] & ~32'h13FC) | (32'(hw_int_in) << 2) | (32'(ipi_int_in) << 12);
`ifdef CSR_TIMER_EN
        if (tcfg_load) begin
            mreg['h42] = mreg['h41] & ~32'h3;
        end else if (old_tcfg[0] && old_cnt != 32'hFFFF_FFFF) begin
            if (old_cnt == 0) begin
                ti_set = 1;
                mreg['h42] = old_tcfg[1] ? (old_tcfg & ~32'h3) : 32'hFFFF_FFFF;
            end else begin
                mreg['h42] = old_cnt - 1;
            end
        end
        if (ti_set) mreg['h05] = mreg['h05] | 32'h800;
        else if (ti_clr) mreg['h05] = mreg['h05] & ~32'h800;
`endif
    endtask

    // Compare every output with the model once per cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_valid && !reset) begin
            check("csr_rvalue", csr_rvalue, csr_re ? mget(int'(csr_num)) : 32'h0);
            check("csr_eentry", csr_eentry, mget('h0C));
            check("csr_era", csr_era, mget('h06));
            check("has_int", {31'd0, has_int}, {31'd0, exp_has_int()});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        csr_we     = 1'b0;
        wb_ex      = 1'b0;
        ertn_flush = 1'b0;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] mask, input logic [31:0] val);
        csr_we     = 1'b1;
        csr_num    = a;
        csr_wmask  = mask;
        csr_wvalue = val;
        tick();
    endtask

    task automatic peek(input logic [13:0] a, input logic [31:0] exp, input string name);
        csr_re  = 1'b1;
        csr_num = a;
        #1;
        check(name, csr_rvalue, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; csr_re = 1'b1; csr_num = '0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
        wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0;
        ertn_flush = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        peek(14'h000, 32'h0000_0008, "crmd_reset");
        peek(14'h006, 32'h0, "era_reset");
        peek(14'h005, 32'h0, "estat_reset");
        peek(14'h3FFF, 32'h0, "unimpl_read");
        check("eentry_reset", csr_eentry, 32'h0);
        check("has_int_reset", {31'd0, has_int}, 32'h0);
        csr_re = 1'b0; csr_num = 14'h000; #1;
        check("re_low", csr_rvalue, 32'h0);
        tick();

        // Masked ERA write.
        wr(14'h006, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
        wr(14'h006, 32'h0000_FFFF, 32'h1234_5678);
        peek(14'h006, 32'hAAAA_5678, "era_masked");
        check("csr_era_port", csr_era, 32'hAAAA_5678);

        // Field masks of ECFG, EENTRY, SAVE.
        wr(14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        peek(14'h004, 32'h0000_1BFF, "ecfg_mask");
        wr(14'h004, 32'hFFFF_FFFF, 32'h0);
        wr(14'h00C, 32'hFFFF_FFFF, 32'h1C00_8FFF);
        peek(14'h00C, 32'h1C00_8FC0, "eentry_va");
        wr(14'h032, 32'hFF00_FF00, 32'h1234_5678);
        peek(14'h032, 32'h1200_5600, "save2_masked");
        wr(14'h007, 32'hFFFF_FFFF, 32'hDEAD_0000);

        // Exception with a colliding ERA write, then ertn.
        wr(14'h000, 32'h0000_0007, 32'h0000_0007);
        peek(14'h000, 32'h0000_000F, "crmd_written");
        wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0100; wb_vaddr = 32'h1234_5678;
        csr_we = 1'b1; csr_num = 14'h006; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'hFFFF_FFFF;
        tick();
        peek(14'h000, 32'h0000_0008, "crmd_after_ex");
        peek(14'h001, 32'h0000_0007, "prmd_after_ex");
        peek(14'h005, 32'h000B_0000, "estat_ecode");
        peek(14'h006, 32'h1C00_0100, "era_after_ex");
        peek(14'h007, 32'hDEAD_0000, "badv_kept");
        ertn_flush = 1'b1;
        tick();
        peek(14'h000, 32'h0000_000F, "crmd_after_ertn");

        // ADEF exception records BADV and the subcode.
        wb_ex = 1'b1; wb_ecode = 6'h08; wb_esubcode = 9'h1A3; wb_pc = 32'h1C00_0200; wb_vaddr = 32'hBADD_0008;
        tick();
        peek(14'h007, 32'hBADD_0008, "badv_adef");
        peek(14'h005, 32'h68C8_0000, "estat_adef");
        ertn_flush = 1'b1;
        tick();
        peek(14'h000, 32'h0000_000F, "crmd_ertn2");

        // ESTAT: only IS[1:0] is software-writable.
        wr(14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        peek(14'h005, 32'h68C8_0003, "estat_sw_write");
        wr(14'h005, 32'h0000_0003, 32'h0);

        // Hardware interrupt and IPI.
        hw_int_in = 8'h01;
        tick();
        peek(14'h005, 32'h68C8_0004, "estat_hw_sample");
        check("has_int_lie0", {31'd0, has_int}, 32'h0);
        wr(14'h004, 32'hFFFF_FFFF, 32'h0000_0004);
        wr(14'h000, 32'h0000_0004, 32'h0000_0004);
        check("has_int_hw", {31'd0, has_int}, 32'h1);
        hw_int_in = 8'h00;
        tick();
        check("has_int_hw_drop", {31'd0, has_int}, 32'h0);
        ipi_int_in = 1'b1;
        wr(14'h004, 32'hFFFF_FFFF, 32'h0000_1000);
        check("has_int_ipi", {31'd0, has_int}, 32'h1);
        ipi_int_in = 1'b0;
        tick();
        check("has_int_ipi_drop", {31'd0, has_int}, 32'h0);

`ifdef CSR_TIMER_EN
        // One-shot timer.
        wr(14'h004, 32'hFFFF_FFFF, 32'h0000_0800);
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0011);
        peek(14'h042, 32'd16, "tval_loaded");
        for (int i = 1; i <= 16; i++) begin
            tick();
            peek(14'h042, 32'(16 - i), "tval_count");
            check("has_int_pending", {31'd0, has_int}, 32'h0);
        end
        tick();
        peek(14'h005, 32'h68C8_0800, "estat_ti_set");
        check("has_int_timer", {31'd0, has_int}, 32'h1);
        peek(14'h042, 32'hFFFF_FFFF, "tval_idle");
        wr(14'h044, 32'h0000_0001, 32'h0000_0001);
        peek(14'h005, 32'h68C8_0000, "estat_ti_clr");
        check("has_int_ticlr", {31'd0, has_int}, 32'h0);

        // Periodic timer with a TICLR write every cycle: IS[11] shows only the fire edges.
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0013);
        for (int k = 1; k <= 51; k++) begin
            csr_we = 1'b1; csr_num = 14'h044; csr_wmask = 32'h1; csr_wvalue = 32'h1;
            tick();
            peek(14'h005, (k % 17 == 0) ? 32'h68C8_0800 : 32'h68C8_0000, "periodic_is11");
        end
        wr(14'h041, 32'hFFFF_FFFF, 32'h0);
        wr(14'h044, 32'h1, 32'h1);
`else
        // Timer addresses are absent: writes ignored, reads 0, IS[11] never sets.
        wr(14'h004, 32'hFFFF_FFFF, 32'h0000_0800);
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0011);
        peek(14'h041, 32'h0, "tcfg_absent");
        peek(14'h042, 32'h0, "tval_absent");
        for (int i = 0; i < 20; i++) tick();
        peek(14'h005, 32'h68C8_0000, "is11_absent");
        check("has_int_no_timer", {31'd0, has_int}, 32'h0);
`endif
        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
